uart_pic_wr_ctrl: RTL and testbench
===================================

UART_PIC_WR_CTRL -- requirements
Module: uart_pic_wr_ctrl

Interface
REQ-001 The block SHALL have parameter PIC_W, default 'd100, meaning image width in pixels.
REQ-002 The block SHALL have parameter PIC_H, default 'd100, meaning image height in pixels.
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame-start marker byte.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 'd104_166, meaning the maximum idle gap between bytes inside a frame (two byte-times at 9600 baud, 50 MHz).
REQ-005 sys_clk  input  1  single clock for all logic, 50 MHz.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pi_data  input  8  received UART byte, valid only when pi_flag is high.
REQ-008 pi_flag  input  1  one-cycle strobe marking pi_data valid.
REQ-009 disp_vblank  input  1  level, high while the display is in vertical blanking, already synchronous to sys_clk.
REQ-010 wr_en  output  1  image-RAM write enable, one-cycle pulse.
REQ-011 wr_addr  output  15  image-RAM write address (two banks of PIC_W*PIC_H).
REQ-012 wr_data  output  8  image-RAM write data (RGB332 pixel).
REQ-013 rd_bank  output  1  bank the display reads; the write bank is always ~rd_bank.
REQ-014 busy  output  1  high in states RECV and SWAP_WAIT.
REQ-015 frame_done  output  1  one-cycle pulse when rd_bank toggles.
REQ-016 err_timeout  output  1  one-cycle pulse when a frame is abandoned on timeout.

Function
REQ-017 The block SHALL implement states IDLE, RECV and SWAP_WAIT.
REQ-018 In IDLE, pi_flag with pi_data==SYNC_BYTE SHALL move to RECV and clear pix_cnt to 0; all other bytes SHALL be discarded.
REQ-019 In RECV, each pi_flag SHALL produce wr_en=1 on the next cycle with wr_data=pi_data and wr_addr=(~rd_bank)*PIC_W*PIC_H+pix_cnt, then increment pix_cnt (latency exactly 1 cycle).
REQ-020 In RECV, SYNC_BYTE values SHALL be treated as ordinary pixel data.
REQ-021 The write at pix_cnt==PIC_W*PIC_H-1 SHALL move the state to SWAP_WAIT and SHALL leave pix_cnt at 0 (no wrap into the other bank).
REQ-022 In RECV, a timeout counter SHALL clear on every pi_flag and increment otherwise; on reaching TIMEOUT_CYC-1 it SHALL pulse err_timeout, return to IDLE and leave rd_bank unchanged.
REQ-023 When pi_flag and timeout expiry coincide, pi_flag SHALL win: the byte is written and the counter clears.
REQ-024 In SWAP_WAIT, pi_flag bytes SHALL be discarded with no write.
REQ-025 In SWAP_WAIT, disp_vblank high SHALL toggle rd_bank, pulse frame_done on the same edge and return to IDLE; if disp_vblank is already high on entry, the swap SHALL occur on the next cycle.
REQ-026 wr_en SHALL never be high in IDLE or SWAP_WAIT except for the final RECV write issued in the cycle the state moves to SWAP_WAIT.
REQ-027 The timeout counter SHALL be held at 0 outside RECV.

Reset
REQ-028 Assertion of sys_rst_n low SHALL immediately force state=IDLE, pix_cnt=0, timeout counter=0, wr_en=0, wr_addr=0, wr_data=0, rd_bank=0, busy=0, frame_done=0 and err_timeout=0.
REQ-029 Reset during RECV SHALL abandon the partial frame with no frame_done or err_timeout pulse.

Structure
REQ-030 A shared package SHALL hold PIC_W, PIC_H, PIX_NUM=PIC_W*PIC_H, the address width and the state encoding, for reuse by the display-side reader.
REQ-031 The inter-byte timeout counter SHALL be one sub-module, byte_timeout_cnt (inputs clear/enable; output expire pulse).

Verification
REQ-032 Reset, then bytes A5 + 10000 bytes (value = index mod 256) -> 10000 writes to addresses 10000..19999 (write bank 1), then disp_vblank pulse -> rd_bank 0->1 and one frame_done.
REQ-033 Second full frame after REQ-032 -> writes to addresses 0..9999 and rd_bank 1->0.
REQ-034 Bytes 3C, 00, A5, A5, 11 in IDLE -> first two discarded; writes A5@addr 10000 and 11@addr 10001.
REQ-035 A5 + 500 bytes, then silence of TIMEOUT_CYC cycles -> exactly one err_timeout pulse, state IDLE, rd_bank unchanged; a following full frame starts again at pix_cnt 0.
REQ-036 Full frame with disp_vblank held low for 1000 cycles while 5 extra bytes arrive -> no writes, busy=1; disp_vblank high -> swap on the next edge; pi_flag coincident with timeout expiry is written.

Source files
------------

// File: rtl/uart_pic_wr_ctrl_pkg.sv
// rtl/uart_pic_wr_ctrl_pkg.sv - shared image geometry, address width and FSM encoding
package uart_pic_wr_ctrl_pkg;

  // Default image geometry. The display-side reader uses the same values.
  localparam int PIC_W   = 100;
  localparam int PIC_H   = 100;
  localparam int PIX_NUM = PIC_W * PIC_H;

  // Two banks of PIX_NUM pixels share one address space.
  localparam int ADDR_W  = $clog2(2 * PIX_NUM);
  localparam int DATA_W  = 8;

  localparam logic [DATA_W-1:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int                TIMEOUT_CYC_DEF = 104_166;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } wr_state_t;

  // Bank 0 occupies [0, pix_num); bank 1 sits directly above it.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic bank,
                                                  input logic [ADDR_W-1:0] pix,
                                                  input int pix_num);
    logic [ADDR_W-1:0] base;
    base = bank ? ADDR_W'(pix_num) : '0;
    return base + pix;
  endfunction

endpackage

// File: rtl/uart_pic_wr_ctrl_if.sv
// rtl/uart_pic_wr_ctrl_if.sv - byte input, image-RAM write port and frame status bundle
interface uart_pic_wr_ctrl_if;
  import uart_pic_wr_ctrl_pkg::*;

  // received UART byte stream
  logic [DATA_W-1:0] pi_data;
  logic              pi_flag;
  // display timing
  logic              disp_vblank;
  // image-RAM write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  // frame status
  logic              rd_bank;
  logic              busy;
  logic              frame_done;
  logic              err_timeout;

  // write controller side
  modport slave (
    input  pi_data, pi_flag, disp_vblank,
    output wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, err_timeout
  );

  // byte source / RAM / display side
  modport master (
    output pi_data, pi_flag, disp_vblank,
    input  wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, err_timeout
  );

endinterface

// File: rtl/byte_timeout_cnt.sv
// rtl/byte_timeout_cnt.sv - inter-byte idle-gap counter with a one-cycle expire strobe
module byte_timeout_cnt #(
  parameter int TIMEOUT_CYC = 104_166
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Expiry only when no byte arrives this cycle: a byte always wins.
  assign expire = enable && !clear && (cnt == LAST);

  // Count idle cycles while enabled; held at zero otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!enable || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pic_wr_ctrl.sv
// rtl/uart_pic_wr_ctrl.sv - UART byte stream to double-buffered image RAM write controller
module uart_pic_wr_ctrl #(
  parameter int          PIC_W       = uart_pic_wr_ctrl_pkg::PIC_W,
  parameter int          PIC_H       = uart_pic_wr_ctrl_pkg::PIC_H,
  parameter logic [7:0]  SYNC_BYTE   = uart_pic_wr_ctrl_pkg::SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYC = uart_pic_wr_ctrl_pkg::TIMEOUT_CYC_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_pic_wr_ctrl_if.slave  bus
);
  import uart_pic_wr_ctrl_pkg::*;

  localparam int                PIX_TOT  = PIC_W * PIC_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_TOT - 1);

  wr_state_t         state;
  logic [ADDR_W-1:0] pix_cnt;
  logic              tmo_expire;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              rd_bank_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              err_timeout_q;

  byte_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timeout_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (bus.pi_flag),
    .enable    (state == ST_RECV),
    .expire    (tmo_expire)
  );

  // Frame FSM: sync hunt, pixel capture into the back bank, swap at vblank.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      pix_cnt       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_bank_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.pi_flag && (bus.pi_data == SYNC_BYTE)) begin
            state   <= ST_RECV;
            busy_q  <= 1'b1;
            pix_cnt <= '0;
          end
        end
        ST_RECV: begin
          if (bus.pi_flag) begin
            // Sync-valued bytes are plain pixels here.
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.pi_data;
            wr_addr_q <= bank_addr(~rd_bank_q, pix_cnt, PIX_TOT);
            if (pix_cnt == LAST_PIX) begin
              // Stop at the bank end instead of spilling into the front bank.
              pix_cnt <= '0;
              state   <= ST_SWAP_WAIT;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
            end
          end else if (tmo_expire) begin
            err_timeout_q <= 1'b1;
            pix_cnt       <= '0;
            busy_q        <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_SWAP_WAIT: begin
          // Complete frame is held back until blanking so the reader never tears.
          if (bus.disp_vblank) begin
            rd_bank_q    <= ~rd_bank_q;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_pic_wr_ctrl.sv
// tb/tb_uart_pic_wr_ctrl.sv - directed self-checking bench for uart_pic_wr_ctrl
module tb_uart_pic_wr_ctrl;

  localparam int         PIX  = 100 * 100;
  localparam int         TMO  = 300;
  localparam logic [7:0] SYNC = 8'hA5;

  logic sys_clk;
  logic sys_rst_n;

  uart_pic_wr_ctrl_if bus ();

  uart_pic_wr_ctrl #(
    .PIC_W       (100),
    .PIC_H       (100),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- frame-level model ----------------
  bit          m_active  = 0;
  bit          m_waiting = 0;
  int          m_count   = 0;
  int          m_silent  = 0;
  bit          m_bank    = 0;
  logic        e_wr_en   = 0;
  logic [14:0] e_addr    = '0;
  logic [7:0]  e_data    = '0;
  logic        e_fd      = 0;
  logic        e_err     = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_active = 0; m_waiting = 0; m_count = 0; m_silent = 0; m_bank = 0;
      e_wr_en = 0; e_addr = '0; e_data = '0; e_fd = 0; e_err = 0;
    end else begin
      e_wr_en = 0; e_fd = 0; e_err = 0;
      if (m_waiting) begin
        if (bus.disp_vblank) begin
          m_bank    = !m_bank;
          e_fd      = 1;
          m_waiting = 0;
        end
      end else if (m_active) begin
        if (bus.pi_flag) begin
          e_wr_en  = 1;
          e_addr   = 15'((1 - int'(m_bank)) * PIX + m_count);
          e_data   = bus.pi_data;
          m_count  = m_count + 1;
          m_silent = 0;
          if (m_count == PIX) begin
            m_active = 0; m_waiting = 1; m_count = 0;
          end
        end else begin
          m_silent = m_silent + 1;
          if (m_silent == TMO) begin
            e_err = 1; m_active = 0; m_count = 0; m_silent = 0;
          end
        end
      end else if (bus.pi_flag && bus.pi_data == SYNC) begin
        m_active = 1; m_count = 0; m_silent = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int wr_addr_log[$];
  int wr_data_log[$];
  int fd_n  = 0;
  int err_n = 0;

  always @(negedge sys_clk) begin
    vectors++;
    if (bus.wr_en !== e_wr_en || bus.rd_bank !== m_bank ||
        bus.busy !== (m_active | m_waiting) || bus.frame_done !== e_fd ||
        bus.err_timeout !== e_err ||
        ((e_wr_en || !sys_rst_n) && (bus.wr_addr !== e_addr || bus.wr_data !== e_data))) begin
      miscompares++;
      $display("FAIL cycle t=%0t got/want wr_en=%b/%b addr=%0d/%0d data=%h/%h bank=%b/%b busy=%b/%b fd=%b/%b err=%b/%b",
               $time, bus.wr_en, e_wr_en, bus.wr_addr, e_addr, bus.wr_data, e_data,
               bus.rd_bank, m_bank, bus.busy, m_active | m_waiting,
               bus.frame_done, e_fd, bus.err_timeout, e_err);
    end
    if (bus.wr_en === 1'b1) begin
      wr_addr_log.push_back(int'(bus.wr_addr));
      wr_data_log.push_back(int'(bus.wr_data));
    end
    if (bus.frame_done === 1'b1) fd_n++;
    if (bus.err_timeout === 1'b1) err_n++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    bus.pi_flag = 1'b1;
    bus.pi_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.pi_flag = 1'b0;
    end
  endtask

  // Let the negedge compare process finish its bookkeeping first.
  task automatic settle();
    #2;
  endtask

  task automatic send_frame();
    send(SYNC);
    for (int i = 0; i < PIX; i++) send(8'(i));
    idle(3);
    settle();
  endtask

  int base, fd0, err0;

  initial begin
    sys_rst_n       = 1'b0;
    bus.pi_flag     = 1'b0;
    bus.pi_data     = 8'h00;
    bus.disp_vblank = 1'b0;
    repeat (3) @(negedge sys_clk);
    settle();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rd_bank", int'(bus.rd_bank), 0);
    chk("reset_wr_addr", int'(bus.wr_addr), 0);
    sys_rst_n = 1'b1;

    // first full frame lands in bank 1
    base = wr_addr_log.size();
    send_frame();
    chk("f1_writes", wr_addr_log.size() - base, PIX);
    chk("f1_first_addr", wr_addr_log[base], 10000);
    chk("f1_last_addr", wr_addr_log[$], 19999);
    chk("f1_last_data", wr_data_log[$], 15);
    chk("f1_busy_wait", int'(bus.busy), 1);
    chk("f1_no_fd_yet", fd_n, 0);
    @(negedge sys_clk); bus.disp_vblank = 1'b1;
    @(negedge sys_clk); bus.disp_vblank = 1'b0;
    idle(2); settle();
    chk("f1_rd_bank", int'(bus.rd_bank), 1);
    chk("f1_fd_count", fd_n, 1);

    // second frame into bank 0, vblank already high at entry to the wait
    bus.disp_vblank = 1'b1;
    base = wr_addr_log.size();
    send_frame();
    bus.disp_vblank = 1'b0;
    chk("f2_writes", wr_addr_log.size() - base, PIX);
    chk("f2_first_addr", wr_addr_log[base], 0);
    chk("f2_last_addr", wr_addr_log[$], 9999);
    chk("f2_rd_bank", int'(bus.rd_bank), 0);
    chk("f2_fd_count", fd_n, 2);

    // junk before sync is dropped, repeated sync is a pixel
    base = wr_addr_log.size();
    err0 = err_n;
    send(8'h3C); idle(1); send(8'h00); idle(1);
    send(8'hA5); idle(1); send(8'hA5); idle(1); send(8'h11); idle(2);
    settle();
    chk("idle_writes", wr_addr_log.size() - base, 2);
    chk("idle_w0_addr", wr_addr_log[base], 10000);
    chk("idle_w0_data", wr_data_log[base], 8'hA5);
    chk("idle_w1_addr", wr_addr_log[base + 1], 10001);
    chk("idle_w1_data", wr_data_log[base + 1], 8'h11);
    idle(TMO + 3); settle();
    chk("idle_tmo_err", err_n - err0, 1);

    // partial frame abandoned on timeout, next frame restarts at pixel 0
    err0 = err_n; fd0 = fd_n;
    send(SYNC);
    for (int i = 0; i < 500; i++) send(8'(i));
    idle(TMO + 3); settle();
    chk("tmo_err_count", err_n - err0, 1);
    chk("tmo_busy", int'(bus.busy), 0);
    chk("tmo_rd_bank", int'(bus.rd_bank), 0);
    chk("tmo_no_fd", fd_n - fd0, 0);
    base = wr_addr_log.size();
    send_frame();
    chk("f3_first_addr", wr_addr_log[base], 10000);
    chk("f3_last_addr", wr_addr_log[$], 19999);

    // bytes during a long swap wait are ignored
    for (int k = 0; k < 5; k++) begin
      send(8'(8'hE0 + k));
      idle(199);
    end
    settle();
    chk("wait_writes", wr_addr_log.size() - base, PIX);
    chk("wait_busy", int'(bus.busy), 1);
    chk("wait_rd_bank", int'(bus.rd_bank), 0);
    @(negedge sys_clk); bus.disp_vblank = 1'b1;
    @(negedge sys_clk); settle();
    chk("wait_swap_bank", int'(bus.rd_bank), 1);
    chk("wait_swap_fd", fd_n - fd0, 1);
    bus.disp_vblank = 1'b0;
    idle(2);

    // byte on the last allowed idle cycle is written
    base = wr_addr_log.size(); err0 = err_n;
    send(SYNC); send(8'h42); idle(TMO - 1); send(8'h43); idle(1); settle();
    chk("edge_writes", wr_addr_log.size() - base, 2);
    chk("edge_w1_addr", wr_addr_log[base + 1], 1);
    chk("edge_w1_data", wr_data_log[base + 1], 8'h43);
    chk("edge_no_err", err_n - err0, 0);
    idle(TMO + 3); settle();
    chk("edge_final_err", err_n - err0, 1);

    // one cycle later the frame is already gone
    base = wr_addr_log.size(); err0 = err_n;
    send(SYNC); send(8'h50); idle(TMO); send(8'h51); idle(3); settle();
    chk("late_writes", wr_addr_log.size() - base, 1);
    chk("late_err", err_n - err0, 1);
    chk("late_busy", int'(bus.busy), 0);

    // reset mid-frame: nothing reported, bank returns to 0
    fd0 = fd_n; err0 = err_n;
    send(SYNC);
    for (int i = 0; i < 50; i++) send(8'(i));
    settle();
    sys_rst_n = 1'b0;
    idle(3); settle();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rd_bank", int'(bus.rd_bank), 0);
    sys_rst_n = 1'b1;
    idle(2); settle();
    chk("rst_no_fd", fd_n - fd0, 0);
    chk("rst_no_err", err_n - err0, 0);
    base = wr_addr_log.size();
    send(SYNC); send(8'h77); idle(2); settle();
    chk("rst_restart_addr", wr_addr_log[base], 10000);

    idle(TMO + 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
